// File: rtl/vadd_float_fp32_add_lanes_if.sv
// Stream bundle (valid/ready/data/last) shared by the input and output sides of the adder.
interface vadd_float_fp32_add_lanes_if #(
    parameter int unsigned DataWidth = 512
);
    logic                 tvalid;
    logic                 tready;
    logic [DataWidth-1:0] tdata;
    logic                 tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/vadd_float_fp32_add_lanes.sv
// Adds a latched fp32 constant to every 32-bit lane of a stream beat.
// The 3-stage pipeline (align, add, normalise/round) stalls as a whole on backpressure.
module vadd_float_fp32_add_lanes #(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
    parameter int unsigned C_ADDER_BIT_WIDTH  = 32
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         ctrl_start,
    input  logic [C_ADDER_BIT_WIDTH-1:0] ctrl_constant,
    vadd_float_fp32_add_lanes_if.slave   s_axis,
    vadd_float_fp32_add_lanes_if.master  m_axis
);
    localparam int Lanes = int'(C_AXIS_TDATA_WIDTH / 32);

    if (C_ADDER_BIT_WIDTH != 32) begin : g_bad_adder_width
        $error("C_ADDER_BIT_WIDTH must be 32");
    end
    if ((C_AXIS_TDATA_WIDTH % 32) != 0) begin : g_bad_data_width
        $error("C_AXIS_TDATA_WIDTH must be a multiple of 32");
    end

    typedef struct packed {
        logic        special;
        logic [31:0] spec_val;
        logic        sign;
        logic        sub;
        logic [7:0]  exp;
        logic [26:0] ma;
        logic [26:0] mb;
    } s1_t;

    typedef struct packed {
        logic        special;
        logic [31:0] spec_val;
        logic        sign;
        logic        sub;
        logic [7:0]  exp;
        logic [27:0] sum;
    } s2_t;

    // Mantissas are 27 bits: hidden, 23 fraction, guard, round, sticky.
    function automatic s1_t align(input logic [31:0] a, input logic [31:0] b);
        s1_t         r;
        logic        a_nan, b_nan, a_inf, b_inf, swap;
        logic [30:0] a_mag, b_mag;
        logic [7:0]  l_exp, s_exp, d;
        logic [22:0] l_frac, s_frac;
        logic [23:0] ms;
        logic [53:0] sh;
        logic [26:0] al;
        logic        stk;
        a_mag  = {a[30:23], (a[30:23] == 8'd0) ? 23'd0 : a[22:0]};
        b_mag  = {b[30:23], (b[30:23] == 8'd0) ? 23'd0 : b[22:0]};
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        swap   = b_mag > a_mag;
        l_exp  = swap ? b[30:23] : a[30:23];
        l_frac = swap ? b[22:0] : a[22:0];
        s_exp  = swap ? a[30:23] : b[30:23];
        s_frac = swap ? a[22:0] : b[22:0];
        d      = l_exp - s_exp;
        ms     = (s_exp == 8'd0) ? 24'd0 : {1'b1, s_frac};
        sh     = {ms, 3'b000, 27'd0} >> d;
        if (d >= 8'd27) begin
            al  = 27'd0;
            stk = |ms;
        end else begin
            al  = sh[53:27];
            stk = |sh[26:0];
        end
        r.ma   = (l_exp == 8'd0) ? 27'd0 : {1'b1, l_frac, 3'b000};
        r.mb   = {al[26:1], al[0] | stk};
        r.exp  = l_exp;
        r.sign = swap ? b[31] : a[31];
        r.sub  = a[31] ^ b[31];
        r.special  = a_nan | b_nan | a_inf | b_inf;
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
            r.spec_val = 32'h7FC0_0000;
        end else if (a_inf) begin
            r.spec_val = {a[31], 8'hFF, 23'd0};
        end else begin
            r.spec_val = {b[31], 8'hFF, 23'd0};
        end
        return r;
    endfunction

    function automatic s2_t add(input s1_t x);
        s2_t r;
        r.special  = x.special;
        r.spec_val = x.spec_val;
        r.sign     = x.sign;
        r.sub      = x.sub;
        r.exp      = x.exp;
        r.sum      = x.sub ? ({1'b0, x.ma} - {1'b0, x.mb}) : ({1'b0, x.ma} + {1'b0, x.mb});
        return r;
    endfunction

    function automatic logic [31:0] norm_round(input s2_t x);
        logic [4:0]  lz;
        logic [26:0] m;
        logic [9:0]  e;
        logic        inc, carry;
        logic [22:0] frac;
        logic [31:0] r;
        lz = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (x.sum[i]) lz = 5'(26 - i);
        end
        if (x.sum[27]) begin
            m = {x.sum[27:2], |x.sum[1:0]};
            e = {2'b00, x.exp} + 10'd1;
        end else begin
            m = x.sum[26:0] << lz;
            e = {2'b00, x.exp} - {5'd0, lz};
        end
        inc   = m[2] & (m[1] | m[0] | m[3]);
        carry = (&m[26:3]) & inc;
        frac  = m[25:3] + {22'd0, inc};
        if (carry) e = e + 10'd1;
        if (x.special) begin
            r = x.spec_val;
        end else if (x.sum == 28'd0) begin
            r = {x.sign & ~x.sub, 31'd0};
        end else if (e[9] || (e == 10'd0)) begin
            r = {x.sign, 31'd0};
        end else if (e >= 10'd255) begin
            r = {x.sign, 8'hFF, 23'd0};
        end else begin
            r = {x.sign, e[7:0], frac};
        end
        return r;
    endfunction

    logic                          en;
    logic [31:0]                   const_q, const_d;
    logic                          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic                          l1_q, l1_d, l2_q, l2_d, l3_q, l3_d;
    s1_t [Lanes-1:0]               s1_q, s1_d;
    s2_t [Lanes-1:0]               s2_q, s2_d;
    logic [C_AXIS_TDATA_WIDTH-1:0] d3_q, d3_d;

    always_comb begin
        // A beat arriving with ctrl_start already sees the new constant.
        const_d = ctrl_start ? ctrl_constant : const_q;
        en      = ~v3_q | m_axis.tready;
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        l1_d = l1_q;
        l2_d = l2_q;
        l3_d = l3_q;
        s1_d = s1_q;
        s2_d = s2_q;
        d3_d = d3_q;
        if (en) begin
            v1_d = s_axis.tvalid;
            l1_d = s_axis.tlast;
            v2_d = v1_q;
            l2_d = l1_q;
            v3_d = v2_q;
            l3_d = l2_q;
            for (int i = 0; i < Lanes; i++) begin
                s1_d[i]          = align(s_axis.tdata[32*i +: 32], const_d);
                s2_d[i]          = add(s1_q[i]);
                d3_d[32*i +: 32] = norm_round(s2_q[i]);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            const_q <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            l1_q    <= 1'b0;
            l2_q    <= 1'b0;
            l3_q    <= 1'b0;
            s1_q    <= '0;
            s2_q    <= '0;
            d3_q    <= '0;
        end else begin
            const_q <= const_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            l1_q    <= l1_d;
            l2_q    <= l2_d;
            l3_q    <= l3_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            d3_q    <= d3_d;
        end
    end

    assign s_axis.tready = en;
    assign m_axis.tvalid = v3_q;
    assign m_axis.tdata  = d3_q;
    assign m_axis.tlast  = l3_q;
endmodule

// File: tb/tb_vadd_float_fp32_add_lanes.sv
// Directed and streaming checks of the lane-wise fp32 constant adder.
module tb_vadd_float_fp32_add_lanes;
    localparam int W     = 512;
    localparam int LANES = W / 32;

    logic        aclk;
    logic        areset;
    logic        ctrl_start;
    logic [31:0] ctrl_constant;
    int          checks;
    int          errors;

    vadd_float_fp32_add_lanes_if #(.DataWidth(W)) s_if ();
    vadd_float_fp32_add_lanes_if #(.DataWidth(W)) m_if ();

    vadd_float_fp32_add_lanes #(
        .C_AXIS_TDATA_WIDTH(W),
        .C_ADDER_BIT_WIDTH (32)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .ctrl_start   (ctrl_start),
        .ctrl_constant(ctrl_constant),
        .s_axis       (s_if),
        .m_axis       (m_if)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [W-1:0] fill(input logic [31:0] v);
        return {LANES{v}};
    endfunction

    // Positive integer (< 2^24) to fp32.
    function automatic logic [31:0] fp_of(input int unsigned n);
        int          p;
        logic [31:0] nn;
        logic [31:0] t;
        p  = 0;
        nn = n;
        for (int i = 0; i < 31; i++) if (nn[i]) p = i;
        t = nn << (23 - p);
        return {1'b0, 8'(127 + p), t[22:0]};
    endfunction

    function automatic logic [W-1:0] beat_in(input int b);
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++) r[32*i +: 32] = fp_of(b * LANES + i + 1);
        return r;
    endfunction

    function automatic logic [W-1:0] beat_out(input int b);
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++) r[32*i +: 32] = fp_of(b * LANES + i + 2);
        return r;
    endfunction

    // Sends one beat with tready held high and waits (bounded) for its result.
    task automatic run_single(input logic [31:0] cst, input logic start, input logic [W-1:0] data,
                              input logic last, output logic [W-1:0] res, output logic res_last,
                              output int lat);
        logic got;
        m_if.tready = 1'b1;
        @(negedge aclk);
        ctrl_start    = start;
        ctrl_constant = cst;
        s_if.tvalid   = 1'b1;
        s_if.tdata    = data;
        s_if.tlast    = last;
        got      = 1'b0;
        lat      = 0;
        res      = '0;
        res_last = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge aclk);
            if (k == 1) begin
                ctrl_start  = 1'b0;
                s_if.tvalid = 1'b0;
                s_if.tlast  = 1'b0;
            end
            if (m_if.tvalid) begin
                got      = 1'b1;
                lat      = k;
                res      = m_if.tdata;
                res_last = m_if.tlast;
            end
        end
        @(negedge aclk);
    endtask

    task automatic test_reset;
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        checks++;
        if (m_if.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_tvalid: got %b expected 0", m_if.tvalid);
        end
        checks++;
        if (m_if.tdata !== '0) begin
            errors++;
            $display("FAIL reset_tdata: got %h expected 0", m_if.tdata);
        end
        checks++;
        if (m_if.tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_tlast: got %b expected 0", m_if.tlast);
        end
        checks++;
        if (s_if.tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready: got %b expected 1", s_if.tready);
        end
        areset = 1'b0;
    endtask

    task automatic test_basic;
        logic [W-1:0] res;
        logic         rl;
        int           lat;
        run_single(32'h4000_0000, 1'b1, fill(32'h3F80_0000), 1'b1, res, rl, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 3", lat);
        end
        checks++;
        if (res !== fill(32'h4040_0000)) begin
            errors++;
            $display("FAIL basic_sum: got %h expected %h", res, fill(32'h4040_0000));
        end
        checks++;
        if (rl !== 1'b1) begin
            errors++;
            $display("FAIL basic_tlast: got %b expected 1", rl);
        end
    endtask

    task automatic test_cancel;
        logic [W-1:0] res, din, exp_d;
        logic         rl;
        int           lat;
        // -1 + {1, 1, 2, 1.5, 1...} -> {0, 0, 1, 0.5, 0...}
        din   = fill(32'h3F80_0000);
        exp_d = fill(32'h0000_0000);
        din[64 +: 32]   = 32'h4000_0000;
        exp_d[64 +: 32] = 32'h3F80_0000;
        din[96 +: 32]   = 32'h3FC0_0000;
        exp_d[96 +: 32] = 32'h3F00_0000;
        run_single(32'hBF80_0000, 1'b1, din, 1'b0, res, rl, lat);
        checks++;
        if (res !== exp_d) begin
            errors++;
            $display("FAIL cancel_sub: got %h expected %h", res, exp_d);
        end
        checks++;
        if (rl !== 1'b0) begin
            errors++;
            $display("FAIL cancel_tlast: got %b expected 0", rl);
        end
        run_single(32'h8000_0000, 1'b1, fill(32'h8000_0000), 1'b0, res, rl, lat);
        checks++;
        if (res !== fill(32'h8000_0000)) begin
            errors++;
            $display("FAIL neg_zero: got %h expected %h", res, fill(32'h8000_0000));
        end
    endtask

    task automatic test_round;
        logic [W-1:0] res, din, exp_d;
        logic         rl;
        int           lat;
        din   = fill(32'h3F80_0000);
        exp_d = fill(32'h3F80_0000);
        din[32 +: 32]   = 32'h3F80_0001;
        exp_d[32 +: 32] = 32'h3F80_0002;
        run_single(32'h3380_0000, 1'b1, din, 1'b0, res, rl, lat);
        checks++;
        if (res[31:0] !== 32'h3F80_0000) begin
            errors++;
            $display("FAIL round_tie_even: got %h expected 3f800000", res[31:0]);
        end
        checks++;
        if (res !== exp_d) begin
            errors++;
            $display("FAIL round_tie_odd: got %h expected %h", res, exp_d);
        end
    endtask

    task automatic test_special;
        logic [W-1:0] res, din, exp_d;
        logic         rl;
        int           lat;
        run_single(32'h7F7F_FFFF, 1'b1, fill(32'h7F7F_FFFF), 1'b0, res, rl, lat);
        checks++;
        if (res !== fill(32'h7F80_0000)) begin
            errors++;
            $display("FAIL overflow_inf: got %h expected %h", res, fill(32'h7F80_0000));
        end
        // +inf with -inf, +1, NaN
        din   = fill(32'hFF80_0000);
        exp_d = fill(32'h7FC0_0000);
        din[32 +: 32]   = 32'h3F80_0000;
        exp_d[32 +: 32] = 32'h7F80_0000;
        din[64 +: 32]   = 32'h7FC0_0001;
        run_single(32'h7F80_0000, 1'b1, din, 1'b0, res, rl, lat);
        checks++;
        if (res !== exp_d) begin
            errors++;
            $display("FAIL inf_nan: got %h expected %h", res, exp_d);
        end
        run_single(32'h0000_0000, 1'b1, fill(32'h0040_0000), 1'b0, res, rl, lat);
        checks++;
        if (res !== fill(32'h0000_0000)) begin
            errors++;
            $display("FAIL denormal_in: got %h expected 0", res);
        end
        // -2^-126 with {2^-126 + 1ulp, 2^-125}: underflow flush and exact min normal
        din   = fill(32'h0080_0001);
        exp_d = fill(32'h0000_0000);
        din[32 +: 32]   = 32'h0100_0000;
        exp_d[32 +: 32] = 32'h0080_0000;
        run_single(32'h8080_0000, 1'b1, din, 1'b0, res, rl, lat);
        checks++;
        if (res !== exp_d) begin
            errors++;
            $display("FAIL underflow: got %h expected %h", res, exp_d);
        end
    endtask

    task automatic test_stream;
        int           in_idx, out_idx, cyc;
        logic         hold, held_l;
        logic [W-1:0] held_d, exp_d;
        @(negedge aclk);
        ctrl_start    = 1'b1;
        ctrl_constant = 32'h3F80_0000;
        @(negedge aclk);
        ctrl_start = 1'b0;
        in_idx  = 0;
        out_idx = 0;
        hold    = 1'b0;
        held_d  = '0;
        held_l  = 1'b0;
        cyc     = 0;
        while (out_idx < 64 && cyc < 3000) begin
            @(negedge aclk);
            cyc++;
            if (hold) begin
                checks++;
                if (m_if.tvalid !== 1'b1 || m_if.tdata !== held_d || m_if.tlast !== held_l) begin
                    errors++;
                    $display("FAIL stream_hold: got v=%b l=%b %h expected v=1 l=%b %h",
                             m_if.tvalid, m_if.tlast, m_if.tdata, held_l, held_d);
                end
            end
            m_if.tready = 1'($urandom_range(0, 1));
            if (in_idx < 64) begin
                s_if.tvalid = 1'($urandom_range(0, 1));
                s_if.tdata  = beat_in(in_idx);
                s_if.tlast  = (in_idx == 63);
            end else begin
                s_if.tvalid = 1'b0;
                s_if.tlast  = 1'b0;
            end
            #4;
            if (m_if.tvalid && m_if.tready) begin
                exp_d = beat_out(out_idx);
                checks++;
                if (m_if.tdata !== exp_d) begin
                    errors++;
                    $display("FAIL stream_data beat %0d: got %h expected %h",
                             out_idx, m_if.tdata, exp_d);
                end
                checks++;
                if (m_if.tlast !== (out_idx == 63)) begin
                    errors++;
                    $display("FAIL stream_tlast beat %0d: got %b expected %b",
                             out_idx, m_if.tlast, (out_idx == 63));
                end
                out_idx++;
            end
            if (s_if.tvalid && s_if.tready) in_idx++;
            hold   = m_if.tvalid && !m_if.tready;
            held_d = m_if.tdata;
            held_l = m_if.tlast;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        checks++;
        if (out_idx != 64) begin
            errors++;
            $display("FAIL stream_count: got %0d beats expected 64", out_idx);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge aclk);
            checks++;
            if (m_if.tvalid !== 1'b0) begin
                errors++;
                $display("FAIL stream_extra: got tvalid %b expected 0", m_if.tvalid);
            end
        end
    endtask

    task automatic test_reset_midflight;
        int stale;
        m_if.tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            ctrl_start    = (k == 0);
            ctrl_constant = 32'h4000_0000;
            s_if.tvalid   = 1'b1;
            s_if.tdata    = fill(32'h3F80_0000);
            s_if.tlast    = 1'b1;
        end
        @(negedge aclk);
        ctrl_start  = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tlast !== 1'b1) begin
            errors++;
            $display("FAIL midflight_full: got v=%b l=%b expected v=1 l=1", m_if.tvalid, m_if.tlast);
        end
        areset = 1'b1;
        @(negedge aclk);
        checks++;
        if (m_if.tvalid !== 1'b0 || m_if.tlast !== 1'b0 || m_if.tdata !== '0) begin
            errors++;
            $display("FAIL midflight_reset: got v=%b l=%b %h expected all 0",
                     m_if.tvalid, m_if.tlast, m_if.tdata);
        end
        checks++;
        if (s_if.tready !== 1'b1) begin
            errors++;
            $display("FAIL midflight_tready: got %b expected 1", s_if.tready);
        end
        areset      = 1'b0;
        m_if.tready = 1'b1;
        stale       = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            if (m_if.tvalid) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL midflight_stale: got %0d beats expected 0", stale);
        end
    endtask

    task automatic test_restart;
        logic [W-1:0] res;
        logic         rl;
        int           lat;
        // Constant register was cleared by reset, so no ctrl_start means x + 0.
        run_single(32'h4000_0000, 1'b0, fill(32'h3F80_0000), 1'b0, res, rl, lat);
        checks++;
        if (res !== fill(32'h3F80_0000)) begin
            errors++;
            $display("FAIL restart_const_zero: got %h expected %h", res, fill(32'h3F80_0000));
        end
        run_single(32'h4000_0000, 1'b1, fill(32'h3F80_0000), 1'b1, res, rl, lat);
        checks++;
        if (res !== fill(32'h4040_0000) || rl !== 1'b1 || lat !== 3) begin
            errors++;
            $display("FAIL restart_sum: got %h l=%b lat=%0d expected %h l=1 lat=3",
                     res, rl, lat, fill(32'h4040_0000));
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        areset        = 1'b1;
        ctrl_start    = 1'b0;
        ctrl_constant = '0;
        s_if.tvalid   = 1'b0;
        s_if.tdata    = '0;
        s_if.tlast    = 1'b0;
        m_if.tready   = 1'b1;
        test_reset();
        test_basic();
        test_cancel();
        test_round();
        test_special();
        test_stream();
        test_reset_midflight();
        test_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
